// File: rtl/dac_frame_sched_pkg.sv
// Shared types and default sizing for the DAC frame scheduler.
// State encodings are 3-bit to leave room for future states.
package dac_frame_sched_pkg;

  localparam int unsigned DEF_DW    = 12;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_PW    = 16;
  localparam int unsigned DEF_TMO   = 255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED      = 3'd1,
    ST_LAUNCH     = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4
  } sched_state_e;

  // Saturating 8-bit increment used by the event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Small synchronous show-ahead FIFO holding host DAC words.
// A push while full is dropped; a pop while empty is ignored.
module sched_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  output logic [DW-1:0]            rd_data_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c    = (level == (AW+1)'(DEPTH));
  assign empty_c   = (level == '0);
  assign do_push   = push && !full_c;
  assign do_pop    = pop && !empty_c;
  assign rd_data_c = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dac_frame_sched.sv
// Launches one DAC serial frame per period tick from a word FIFO and
// follows the serializer chip-select to find frame start and end.
module dac_frame_sched
  import dac_frame_sched_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned TMO   = DEF_TMO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [PW-1:0]          period,
  input  logic                   wr_valid,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   cs_o,
  output logic                   flag_cs,
  output logic                   we_en,
  output logic [DW-1:0]          dac_word,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             underrun_cnt,
  output logic [7:0]             overrun_cnt,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int unsigned TW = $clog2(TMO + 1);

  sched_state_e  state, state_d;
  logic [TW-1:0] wcnt, wcnt_d;
  logic [PW-1:0] tcnt, period_eff, term;
  logic          tick;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] fifo_head;
  logic          under_inc;
  logic          over_inc;
  logic          timeout_evt;

  sched_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .wr_data   (wr_data),
    .pop       (pop),
    .rd_data_c (fifo_head),
    .level     (fifo_level),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  assign wr_ready = !fifo_full;

  // Period timer: a counter already past a shortened period wraps without a tick.
  assign period_eff = (period == '0) ? PW'(1) : period;
  assign term       = period_eff - PW'(1);
  assign tick       = run && (tcnt == term);

  always_ff @(posedge clk) begin
    if (!rst || !run)      tcnt <= '0;
    else if (tcnt >= term) tcnt <= '0;
    else                   tcnt <= tcnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  // Each wait state allows TMO cycles; the timeout fires on the edge ending the last.
  always_comb begin
    state_d     = state;
    wcnt_d      = wcnt;
    pop         = 1'b0;
    under_inc   = 1'b0;
    over_inc    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_LAUNCH;
          end else begin
            under_inc = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        over_inc = tick;
        wcnt_d   = '0;
        state_d  = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        over_inc = tick;
        if (!cs_o) begin
          wcnt_d  = '0;
          state_d = ST_WAIT_DONE;
        end else if (wcnt == TW'(TMO - 1)) begin
          timeout_evt = 1'b1;
          state_d     = ST_ARMED;
        end else begin
          wcnt_d = wcnt + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        over_inc = tick;
        if (cs_o) begin
          state_d = run ? ST_ARMED : ST_IDLE;
        end else if (wcnt == TW'(TMO - 1)) begin
          timeout_evt = 1'b1;
          state_d     = ST_ARMED;
        end else begin
          wcnt_d = wcnt + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Launch strobes and the held frame word; a pop is exactly the entry into LAUNCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_cs  <= 1'b0;
      we_en    <= 1'b0;
      dac_word <= '0;
    end else begin
      flag_cs <= pop;
      we_en   <= pop;
      if (pop) dac_word <= fifo_head;
    end
  end

  // Error reporting; a clear always wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (!rst || err_clr) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (under_inc)   underrun_cnt <= sat_inc8(underrun_cnt);
      if (over_inc)    overrun_cnt  <= sat_inc8(overrun_cnt);
      if (timeout_evt) timeout_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_frame_sched.sv
// Directed bench for dac_frame_sched with a small serializer chip-select model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dac_frame_sched;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned TMO   = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [PW-1:0] period = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          cs_o = 1'b1;
  logic          flag_cs;
  logic          we_en;
  logic [DW-1:0] dac_word;
  logic [3:0]    fifo_level;
  logic [7:0]    underrun_cnt;
  logic [7:0]    overrun_cnt;
  logic          timeout_err;
  logic          err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int   ser_delay = 2;
  int   ser_low   = 5;
  logic ser_act   = 1'b0;
  int   ser_cnt   = 0;

  dac_frame_sched #(.DW(DW), .DEPTH(DEPTH), .PW(PW), .TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .period       (period),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .cs_o         (cs_o),
    .flag_cs      (flag_cs),
    .we_en        (we_en),
    .dac_word     (dac_word),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  // Serializer: cs_o drops ser_delay cycles after flag_cs and rises ser_low cycles later.
  always @(negedge clk) begin
    if (flag_cs === 1'b1) begin
      ser_act = (ser_low != 0);
      ser_cnt = 0;
    end else if (ser_act) begin
      ser_cnt++;
      if (ser_cnt == ser_delay) cs_o = 1'b0;
      if (ser_cnt == ser_delay + ser_low) begin
        cs_o    = 1'b1;
        ser_act = 1'b0;
      end
    end
  end

  task automatic wait_flag(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (flag_cs === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (flag_cs !== 1'b0) begin n_err++; $display("FAIL rst_flag_cs: got %b want 0", flag_cs); end
    n_vec++; if (we_en !== 1'b0) begin n_err++; $display("FAIL rst_we_en: got %b want 0", we_en); end
    n_vec++; if (dac_word !== 12'h000) begin n_err++; $display("FAIL rst_dac_word: got %h want 000", dac_word); end
    n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    n_vec++; if (underrun_cnt !== 8'd0) begin n_err++; $display("FAIL rst_underrun: got %0d want 0", underrun_cnt); end
    n_vec++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL rst_overrun: got %0d want 0", overrun_cnt); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frames();
    int n;
    ser_delay = 2; ser_low = 5;
    wr_valid = 1'b1; wr_data = 12'h123; @(negedge clk);
    wr_data = 12'h456; @(negedge clk);
    wr_data = 12'h789; @(negedge clk);
    wr_valid = 1'b0;
    n_vec++; if (fifo_level !== 4'd3) begin n_err++; $display("FAIL basic_level3: got %0d want 3", fifo_level); end
    period = 16'd10; run = 1'b1;
    // First tick lands period cycles after run rises; flag follows one cycle later.
    wait_flag(40, n);
    n_vec++; if (n !== 10) begin n_err++; $display("FAIL basic_first_lat: got %0d want 10", n); end
    n_vec++; if (dac_word !== 12'h123) begin n_err++; $display("FAIL basic_word0: got %h want 123", dac_word); end
    n_vec++; if (we_en !== 1'b1) begin n_err++; $display("FAIL basic_we_en: got %b want 1", we_en); end
    wait_flag(40, n);
    n_vec++; if (n !== 10) begin n_err++; $display("FAIL basic_gap1: got %0d want 10", n); end
    n_vec++; if (dac_word !== 12'h456) begin n_err++; $display("FAIL basic_word1: got %h want 456", dac_word); end
    wait_flag(40, n);
    n_vec++; if (n !== 10) begin n_err++; $display("FAIL basic_gap2: got %0d want 10", n); end
    n_vec++; if (dac_word !== 12'h789) begin n_err++; $display("FAIL basic_word2: got %h want 789", dac_word); end
    repeat (5) @(negedge clk);
    n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL basic_level0: got %0d want 0", fifo_level); end
    n_vec++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL basic_overrun: got %0d want 0", overrun_cnt); end
    run = 1'b0;
    repeat (15) @(negedge clk);
    n_vec++; if (underrun_cnt !== 8'd0) begin n_err++; $display("FAIL basic_underrun: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_underrun();
    int nf;
    nf = 0;
    period = 16'd5; run = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (flag_cs === 1'b1) nf++;
    end
    n_vec++; if (nf !== 0) begin n_err++; $display("FAIL under_no_flag: got %0d want 0", nf); end
    n_vec++; if (underrun_cnt !== 8'd10) begin n_err++; $display("FAIL under_count: got %0d want 10", underrun_cnt); end
    run = 1'b0;
    repeat (3) @(negedge clk);
    // Period 0 acts as 1: one underrun per cycle once ARMED, saturating at 255.
    period = 16'd0; run = 1'b1;
    repeat (300) @(negedge clk);
    n_vec++; if (underrun_cnt !== 8'd255) begin n_err++; $display("FAIL under_saturate: got %0d want 255", underrun_cnt); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++; if (underrun_cnt !== 8'd0) begin n_err++; $display("FAIL under_clear_wins: got %0d want 0", underrun_cnt); end
    @(negedge clk);
    n_vec++; if (underrun_cnt !== 8'd1) begin n_err++; $display("FAIL under_after_clear: got %0d want 1", underrun_cnt); end
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    int n;
    int bad;
    pulse_clear();
    ser_delay = 2; ser_low = 12;
    wr_valid = 1'b1; wr_data = 12'hA5A; @(negedge clk);
    wr_data = 12'h3C3; @(negedge clk);
    wr_valid = 1'b0;
    period = 16'd4; run = 1'b1;
    wait_flag(20, n);
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL over_first_lat: got %0d want 4", n); end
    n_vec++; if (dac_word !== 12'hA5A) begin n_err++; $display("FAIL over_word0: got %h want a5a", dac_word); end
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (dac_word !== 12'hA5A) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL over_hold0: got %0d changes want 0", bad); end
    // Frame 1 spans three ticks; the next tick finds ARMED and launches word 2.
    @(negedge clk);
    n_vec++; if (flag_cs !== 1'b1) begin n_err++; $display("FAIL over_flag2: got %b want 1", flag_cs); end
    n_vec++; if (dac_word !== 12'h3C3) begin n_err++; $display("FAIL over_word1: got %h want 3c3", dac_word); end
    n_vec++; if (overrun_cnt !== 8'd3) begin n_err++; $display("FAIL over_count1: got %0d want 3", overrun_cnt); end
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (dac_word !== 12'h3C3) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL over_hold1: got %0d changes want 0", bad); end
    @(negedge clk);
    n_vec++; if (overrun_cnt !== 8'd6) begin n_err++; $display("FAIL over_count2: got %0d want 6", overrun_cnt); end
    n_vec++; if (underrun_cnt !== 8'd0) begin n_err++; $display("FAIL over_underrun: got %0d want 0", underrun_cnt); end
    run = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    pulse_clear();
    ser_low = 0;
    wr_valid = 1'b1; wr_data = 12'h0F0; @(negedge clk);
    wr_valid = 1'b0;
    period = 16'd20; run = 1'b1;
    wait_flag(30, n);
    n_vec++; if (n !== 20) begin n_err++; $display("FAIL tmo_first_lat: got %0d want 20", n); end
    // TMO cycles in WAIT_START after the LAUNCH cycle, then timeout_err registers.
    repeat (255) @(negedge clk);
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
    @(negedge clk);
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_set: got %b want 1", timeout_err); end
    n_vec++; if (overrun_cnt !== 8'd12) begin n_err++; $display("FAIL tmo_overrun: got %0d want 12", overrun_cnt); end
    wr_valid = 1'b1; wr_data = 12'h0E0;
    @(negedge clk);
    wr_valid = 1'b0;
    pulse_clear();
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    n_vec++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL tmo_clear_over: got %0d want 0", overrun_cnt); end
    // Back in ARMED, so the next tick launches the freshly pushed word.
    repeat (2) @(negedge clk);
    n_vec++; if (flag_cs !== 1'b1) begin n_err++; $display("FAIL tmo_rearm_flag: got %b want 1", flag_cs); end
    n_vec++; if (dac_word !== 12'h0E0) begin n_err++; $display("FAIL tmo_rearm_word: got %h want 0e0", dac_word); end
    run = 1'b0;
    repeat (300) @(negedge clk);
    pulse_clear();
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    ser_delay = 2; ser_low = 3;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 12'h100 + 12'(i);
      @(negedge clk);
    end
    wr_data = 12'h1FF;
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", wr_ready); end
    n_vec++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL full_level: got %0d want 8", fifo_level); end
    repeat (3) @(negedge clk);
    n_vec++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL full_drop: got %0d want 8", fifo_level); end
    period = 16'd0; run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    n_vec++; if (fifo_level !== 4'd7) begin n_err++; $display("FAIL full_pop_level: got %0d want 7", fifo_level); end
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready: got %b want 1", wr_ready); end
    n_vec++; if (dac_word !== 12'h100) begin n_err++; $display("FAIL full_pop_word: got %h want 100", dac_word); end
    @(negedge clk);
    wr_valid = 1'b0;
    n_vec++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL full_ninth: got %0d want 8", fifo_level); end
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_ninth_ready: got %b want 0", wr_ready); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    ser_delay = 2; ser_low = 12;
    period = 16'd20; run = 1'b1;
    wait_flag(30, n);
    n_vec++; if (n !== 20) begin n_err++; $display("FAIL mrst_lat: got %0d want 20", n); end
    n_vec++; if (dac_word !== 12'h101) begin n_err++; $display("FAIL mrst_word: got %h want 101", dac_word); end
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (flag_cs !== 1'b0) begin n_err++; $display("FAIL mrst_flag: got %b want 0", flag_cs); end
    n_vec++; if (dac_word !== 12'h000) begin n_err++; $display("FAIL mrst_dac_word: got %h want 000", dac_word); end
    n_vec++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL mrst_level: got %0d want 0", fifo_level); end
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b want 1", wr_ready); end
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b1; wr_data = 12'h777;
    @(negedge clk);
    wr_valid = 1'b0;
    // From IDLE with a cleared timer the flag appears period cycles after release.
    wait_flag(40, n);
    n_vec++; if (n !== 19) begin n_err++; $display("FAIL mrst_idle_lat: got %0d want 19", n); end
    n_vec++; if (dac_word !== 12'h777) begin n_err++; $display("FAIL mrst_new_word: got %h want 777", dac_word); end
    run = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_underrun();
    test_overrun();
    test_timeout();
    test_fifo_full();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
